noc_rsp_deframer: RTL and testbench
===================================

NOC_RSP_DEFRAMER -- requirements
Module: noc_rsp_deframer

Interface
REQ-001 Parameter PL_DEPTH, default 16, payload FIFO entries (power of 2, min 4).
REQ-002 Parameter DESC_DEPTH, default 4, descriptor FIFO entries (power of 2, min 2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 noc_from_dev_ctl  in  1  switch response stream control bit; no backpressure, sampled every cycle.
REQ-006 noc_from_dev_data  in  8  switch response stream byte.
REQ-007 pl_valid  out  1  payload byte available.
REQ-008 pl_data  out  8  payload byte.
REQ-009 pl_last  out  1  final payload byte of its packet.
REQ-010 pl_ready  in  1  consumer accepts payload; transfer when pl_valid && pl_ready.
REQ-011 desc_valid  out  1  packet descriptor available.
REQ-012 desc_cmd  out  8  command byte of packet.
REQ-013 desc_src  out  8  source device ID (8'h40..8'h43 in normal traffic).
REQ-014 desc_len  out  6  payload byte count, 0..63.
REQ-015 desc_err  out  2  0 OK, 1 TRUNC, 2 LONG, 3 OVF.
REQ-016 desc_ready  in  1  consumer accepts descriptor; transfer when desc_valid && desc_ready.
REQ-017 drop_cnt  out  8  saturating count of discarded input bytes/packets.

Function
REQ-018 Framing: header = ctl=1, data!=0 (cmd); next ctl=0 byte = src; following ctl=0 bytes = payload; packet closes on any ctl=1 byte.
REQ-019 ctl=1, data=8'h00 is NOP; in IDLE it is ignored.
REQ-020 FSM states IDLE, SRC, DATA, DROP; reset state IDLE.
REQ-021 IDLE: header with descriptor FIFO not full -> latch cmd, clear len/err, go SRC; header with descriptor FIFO full -> drop_cnt+1, go DROP; ctl=0 byte -> drop_cnt+1, stay.
REQ-022 SRC: ctl=0 -> latch src, go DATA; ctl=1 -> push descriptor {cmd, src=0, len=0, err=TRUNC}, then treat byte as in IDLE in the same cycle.
REQ-023 DATA ctl=0: if len<63 and payload byte accepted -> len+1; if len==63 -> byte dropped, err=LONG.
REQ-024 Payload staging: each accepted byte is held in a one-entry staging register; it is pushed to the payload FIFO with last=0 when the next accepted byte arrives, or with last=1 when the packet closes.
REQ-025 Payload overflow: byte arriving when staging is occupied and payload FIFO full is dropped, err=OVF, drop_cnt+1; len not incremented.
REQ-026 DATA ctl=1: flush staging (last=1) if occupied, push descriptor; data=0 -> IDLE; data!=0 -> back-to-back header, handled as in IDLE in the same cycle.
REQ-027 Flush with payload FIFO full: staging byte is held and pushed on the first cycle with space; new packet payload is not pushed ahead of it.
REQ-028 Error priority OVF > LONG > TRUNC; first-set err is overridden only by higher priority.
REQ-029 DROP: discard ctl=0 bytes; on ctl=1 behave as IDLE for that byte.
REQ-030 Zero-payload packet (header, src, terminator): descriptor len=0, err=OK, no payload entry.
REQ-031 Latency: terminator sampled at edge N -> desc_valid high in cycle after edge N; payload byte sampled at edge N -> pl_valid no earlier than cycle after edge N+1.
REQ-032 Both output FIFOs show-ahead; outputs stable while valid && !ready; simultaneous push and pop on a full FIFO is permitted.
REQ-033 drop_cnt saturates at 8'hFF.

Reset
REQ-034 On reset: FSM IDLE, staging empty, both FIFOs empty, pl_valid=0, desc_valid=0, pl_data/pl_last/desc_* =0, drop_cnt=0.
REQ-035 Reset mid-packet discards the partial packet; subsequent ctl=0 bytes before a header are counted as drops.

Structure
REQ-036 Package noc_pkg holds state enum, error enum, NOP constant 8'h00, MAX_LEN=63, byte width.
REQ-037 One sub-module, noc_sync_fifo (parameterised width/depth, show-ahead, full/empty), instantiated for payload (9 bits) and descriptors (24 bits).

Verification
REQ-038 Header 8'h23, src 8'h41, payload AA BB CC, NOP -> pl AA,BB,CC(last=1); desc {23,41,3,OK}.
REQ-039 Header 8'h11 then immediately NOP -> desc {11,00,0,TRUNC}, no payload.
REQ-040 Header 8'h05, src 8'h42, 70 payload bytes, NOP -> 63 bytes out, last on 63rd; desc len=63, err=LONG.
REQ-041 pl_ready=0, 20-byte packet (PL_DEPTH=16) -> 17 bytes kept (16 FIFO + staging), 3 dropped, drop_cnt=3, err=OVF.
REQ-042 Back-to-back headers 8'h01/src 40/DD then 8'h02/src 43/EE, NOP -> two descriptors in order, each len=1, OK; reset asserted mid second packet -> all outputs 0, second descriptor absent.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared types and constants for the NoC response deframer.
//   - state_e : deframer FSM states
//   - err_e   : descriptor error codes; numeric order equals priority
//   - desc_t  : packed descriptor record {cmd, src, len, err} (24 bits)
//   - sat_inc : 8-bit saturating increment used by the drop counter
package noc_pkg;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 6;
   localparam int PL_W   = BYTE_W + 1;            // {last, data}
   localparam int DESC_W = 2 * BYTE_W + LEN_W + 2; // {cmd, src, len, err}

   localparam logic [BYTE_W-1:0] NOP     = 8'h00;
   localparam logic [LEN_W-1:0]  MAX_LEN = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SRC  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } state_e;

   // Encoded so that a larger value always wins: OVF > LONG > TRUNC > OK.
   typedef enum logic [1:0] {
      ERR_OK    = 2'd0,
      ERR_TRUNC = 2'd1,
      ERR_LONG  = 2'd2,
      ERR_OVF   = 2'd3
   } err_e;

   typedef struct packed {
      logic [BYTE_W-1:0] cmd;
      logic [BYTE_W-1:0] src;
      logic [LEN_W-1:0]  len;
      err_e              err;
   } desc_t;

   function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock show-ahead FIFO.
//   clk, reset      : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write request; accepted when not full, or when full and
//                     a pop is accepted in the same cycle
//   pop             : read request; ignored when empty
//   pop_data        : head entry, forced to zero while empty
//   empty, full     : occupancy flags
//   almost_full     : at most one free entry remains
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic             almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty       = (count_q == '0);
   assign full        = (count_q == FULL_CNT);
   assign almost_full = (count_q >= AFULL_CNT);

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Gated so that an empty FIFO presents all-zero outputs.
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/noc_rsp_deframer.sv
// noc_rsp_deframer: splits a switch response byte stream into a payload
// stream and a per-packet descriptor stream.
//   clk, reset          : clock, synchronous active-high reset
//   noc_from_dev_ctl    : 1 = header/terminator/NOP byte, 0 = src/payload byte
//   noc_from_dev_data   : stream byte (no backpressure, sampled every cycle)
//   pl_valid/pl_ready   : payload handshake; pl_data, pl_last describe the byte
//   desc_valid/desc_ready : descriptor handshake; desc_cmd/src/len/err
//   drop_cnt            : saturating count of discarded bytes/packets
//
// Handshake: an output transfer happens on a rising edge where valid and ready
// are both high; while valid is high and ready low, the data outputs hold.
//
// Payload bytes pass through a one-entry staging register so the last byte of
// a packet can be tagged when the terminator arrives. A final byte that cannot
// enter a full payload FIFO stays in staging (marked last) and drains as soon
// as space appears; later bytes can only reach the FIFO through staging, so
// ordering is preserved.
module noc_rsp_deframer
   import noc_pkg::*;
#(
   parameter int PL_DEPTH   = 16,
   parameter int DESC_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              noc_from_dev_ctl,
   input  logic [BYTE_W-1:0] noc_from_dev_data,
   output logic              pl_valid,
   output logic [BYTE_W-1:0] pl_data,
   output logic              pl_last,
   input  logic              pl_ready,
   output logic              desc_valid,
   output logic [BYTE_W-1:0] desc_cmd,
   output logic [BYTE_W-1:0] desc_src,
   output logic [LEN_W-1:0]  desc_len,
   output logic [1:0]        desc_err,
   input  logic              desc_ready,
   output logic [BYTE_W-1:0] drop_cnt
);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] cmd_q, cmd_d;
   logic [BYTE_W-1:0] src_q, src_d;
   logic [LEN_W-1:0]  len_q, len_d;
   err_e              err_q, err_d;
   logic              stg_valid_q, stg_valid_d;
   logic              stg_last_q, stg_last_d;
   logic [BYTE_W-1:0] stg_data_q, stg_data_d;
   logic [BYTE_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              pl_push, pl_pop, pl_empty, pl_full, pl_afull, pl_space;
   logic [PL_W-1:0]   pl_push_data, pl_pop_data;
   logic              desc_push, desc_pop, desc_empty, desc_full, desc_afull;
   desc_t             desc_push_data, desc_pop_data;
   logic              reenter;
   logic              header_ok;

   assign pl_pop   = pl_valid && pl_ready;
   assign pl_space = !pl_full || pl_pop;
   assign desc_pop = desc_valid && desc_ready;

   always_comb begin
      state_d        = state_q;
      cmd_d          = cmd_q;
      src_d          = src_q;
      len_d          = len_q;
      err_d          = err_q;
      stg_valid_d    = stg_valid_q;
      stg_last_d     = stg_last_q;
      stg_data_d     = stg_data_q;
      drop_cnt_d     = drop_cnt_q;
      pl_push        = 1'b0;
      pl_push_data   = '0;
      desc_push      = 1'b0;
      desc_push_data = '0;
      reenter        = 1'b0;
      header_ok      = 1'b0;

      // Drain a closed packet's final byte left behind by a full FIFO.
      if (stg_valid_q && stg_last_q && pl_space) begin
         pl_push      = 1'b1;
         pl_push_data = {1'b1, stg_data_q};
         stg_valid_d  = 1'b0;
         stg_last_d   = 1'b0;
      end

      case (state_q)
         ST_SRC: begin
            if (noc_from_dev_ctl) begin
               desc_push      = 1'b1;
               desc_push_data = '{cmd: cmd_q, src: 8'h00, len: '0, err: ERR_TRUNC};
               reenter        = 1'b1;
            end else begin
               src_d   = noc_from_dev_data;
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (!noc_from_dev_ctl) begin
               if (len_q == MAX_LEN) begin
                  if (err_q < ERR_LONG) err_d = ERR_LONG;
               end else if (!stg_valid_d) begin
                  stg_valid_d = 1'b1;
                  stg_last_d  = 1'b0;
                  stg_data_d  = noc_from_dev_data;
                  len_d       = len_q + 6'd1;
               end else if (pl_space) begin
                  // Staging holds a mid-packet byte: it moves on, new one enters.
                  pl_push      = 1'b1;
                  pl_push_data = {1'b0, stg_data_d};
                  stg_data_d   = noc_from_dev_data;
                  stg_last_d   = 1'b0;
                  len_d        = len_q + 6'd1;
               end else begin
                  err_d      = ERR_OVF;
                  drop_cnt_d = sat_inc(drop_cnt_q);
               end
            end else begin
               if (stg_valid_d && !stg_last_d) begin
                  if (pl_space) begin
                     pl_push      = 1'b1;
                     pl_push_data = {1'b1, stg_data_d};
                     stg_valid_d  = 1'b0;
                  end else begin
                     stg_last_d = 1'b1;
                  end
               end
               desc_push      = 1'b1;
               desc_push_data = '{cmd: cmd_q, src: src_q, len: len_q, err: err_q};
               reenter        = 1'b1;
            end
         end

         ST_DROP: begin
            if (noc_from_dev_ctl) reenter = 1'b1;
         end

         default: ;
      endcase

      // IDLE handling, also applied to the closing byte of SRC/DATA/DROP so a
      // terminator that is itself a header starts the next packet at once.
      if (state_q == ST_IDLE || reenter) begin
         // A descriptor pushed this cycle consumes a slot before the new header.
         header_ok = desc_push ? !desc_afull : !desc_full;
         if (noc_from_dev_ctl) begin
            if (noc_from_dev_data == NOP) begin
               state_d = ST_IDLE;
            end else if (header_ok) begin
               cmd_d   = noc_from_dev_data;
               src_d   = 8'h00;
               len_d   = '0;
               err_d   = ERR_OK;
               state_d = ST_SRC;
            end else begin
               drop_cnt_d = sat_inc(drop_cnt_q);
               state_d    = ST_DROP;
            end
         end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         src_q       <= '0;
         len_q       <= '0;
         err_q       <= ERR_OK;
         stg_valid_q <= 1'b0;
         stg_last_q  <= 1'b0;
         stg_data_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         src_q       <= src_d;
         len_q       <= len_d;
         err_q       <= err_d;
         stg_valid_q <= stg_valid_d;
         stg_last_q  <= stg_last_d;
         stg_data_q  <= stg_data_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   noc_sync_fifo #(.WIDTH(PL_W), .DEPTH(PL_DEPTH)) u_pl_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (pl_push),
      .push_data   (pl_push_data),
      .pop         (pl_pop),
      .pop_data    (pl_pop_data),
      .empty       (pl_empty),
      .full        (pl_full),
      .almost_full (pl_afull)
   );

   noc_sync_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_desc_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (desc_push),
      .push_data   (desc_push_data),
      .pop         (desc_pop),
      .pop_data    (desc_pop_data),
      .empty       (desc_empty),
      .full        (desc_full),
      .almost_full (desc_afull)
   );

   assign pl_valid   = !pl_empty;
   assign pl_last    = pl_pop_data[PL_W-1];
   assign pl_data    = pl_pop_data[BYTE_W-1:0];
   assign desc_valid = !desc_empty;
   assign desc_cmd   = desc_pop_data.cmd;
   assign desc_src   = desc_pop_data.src;
   assign desc_len   = desc_pop_data.len;
   assign desc_err   = desc_pop_data.err;
   assign drop_cnt   = drop_cnt_q;

   // Almost-full of the payload FIFO is not needed by the control logic.
   logic unused_pl_afull;
   assign unused_pl_afull = pl_afull;

endmodule

// File: tb/tb_noc_rsp_deframer.sv
module tb_noc_rsp_deframer;

   logic       clk = 1'b0;
   logic       reset;
   logic       noc_ctl;
   logic [7:0] noc_data;
   logic       pl_valid, pl_last, pl_ready;
   logic [7:0] pl_data;
   logic       desc_valid, desc_ready;
   logic [7:0] desc_cmd, desc_src, drop_cnt;
   logic [5:0] desc_len;
   logic [1:0] desc_err;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   logic [8:0]  pl_q[$];
   logic [23:0] desc_q[$];

   typedef struct {
      logic       ctl;
      logic [7:0] data;
      logic       plv;
      logic [7:0] pld;
      logic       pll;
      logic       dv;
      logic [7:0] cmd;
      logic [7:0] src;
      logic [5:0] len;
      logic [1:0] err;
      logic [7:0] drop;
   } vec_t;

   vec_t vecs[23];

   noc_rsp_deframer #(.PL_DEPTH(16), .DESC_DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .noc_from_dev_ctl  (noc_ctl),
      .noc_from_dev_data (noc_data),
      .pl_valid          (pl_valid),
      .pl_data           (pl_data),
      .pl_last           (pl_last),
      .pl_ready          (pl_ready),
      .desc_valid        (desc_valid),
      .desc_cmd          (desc_cmd),
      .desc_src          (desc_src),
      .desc_len          (desc_len),
      .desc_err          (desc_err),
      .desc_ready        (desc_ready),
      .drop_cnt          (drop_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      noc_ctl  = 1'b1;
      noc_data = 8'h00;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- driver ----------------
   // Drives one stream byte for one edge, then returns the line to NOP.
   task automatic send(input logic c, input logic [7:0] d);
      noc_ctl  = c;
      noc_data = d;
      tick();
      noc_ctl  = 1'b1;
      noc_data = 8'h00;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int n = 0;
      while ((pl_q.size() != 0 || desc_q.size() != 0) && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (pl_q.size() != 0 || desc_q.size() != 0) begin
         errors++;
         $display("FAIL %s: timeout, got %0d pl / %0d desc outstanding expected 0",
                  name, pl_q.size(), desc_q.size());
      end
      tick();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (pl_valid && pl_ready) begin
            checks++;
            if (pl_q.size() == 0) begin
               errors++;
               $display("FAIL pl_unexpected: got %0h expected none", {pl_last, pl_data});
            end else begin
               logic [8:0] e;
               e = pl_q.pop_front();
               if ({pl_last, pl_data} !== e) begin
                  errors++;
                  $display("FAIL pl_byte: got %0h expected %0h", {pl_last, pl_data}, e);
               end
            end
         end
         if (desc_valid && desc_ready) begin
            checks++;
            if (desc_q.size() == 0) begin
               errors++;
               $display("FAIL desc_unexpected: got %0h expected none",
                        {desc_cmd, desc_src, desc_len, desc_err});
            end else begin
               logic [23:0] e;
               e = desc_q.pop_front();
               if ({desc_cmd, desc_src, desc_len, desc_err} !== e) begin
                  errors++;
                  $display("FAIL desc: got %0h expected %0h",
                           {desc_cmd, desc_src, desc_len, desc_err}, e);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   initial begin
      // ctl data | plv pld pll | dv cmd src len err | drop
      vecs[0]  = '{1'b1, 8'h23, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[1]  = '{1'b0, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[2]  = '{1'b0, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[3]  = '{1'b0, 8'hBB, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[4]  = '{1'b0, 8'hCC, 1'b1, 8'hBB, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[5]  = '{1'b1, 8'h00, 1'b1, 8'hCC, 1'b1, 1'b1, 8'h23, 8'h41, 6'd3, 2'd0, 8'd0};
      vecs[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[7]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[8]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'h00, 6'd0, 2'd1, 8'd0};
      vecs[9]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd0};
      vecs[10] = '{1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[11] = '{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[12] = '{1'b0, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[13] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h30, 8'h42, 6'd0, 2'd0, 8'd1};
      vecs[14] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[15] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[16] = '{1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[17] = '{1'b0, 8'hDD, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[18] = '{1'b1, 8'h02, 1'b1, 8'hDD, 1'b1, 1'b1, 8'h01, 8'h40, 6'd1, 2'd0, 8'd1};
      vecs[19] = '{1'b0, 8'h43, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[20] = '{1'b0, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};
      vecs[21] = '{1'b1, 8'h00, 1'b1, 8'hEE, 1'b1, 1'b1, 8'h02, 8'h43, 6'd1, 2'd0, 8'd1};
      vecs[22] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 6'd0, 2'd0, 8'd1};

      pl_ready   = 1'b1;
      desc_ready = 1'b1;
      do_reset();

      // Reset state: every output low.
      check("reset_outputs",
            64'({pl_valid, pl_data, pl_last, desc_valid, desc_cmd, desc_src,
                 desc_len, desc_err, drop_cnt}), 64'd0);

      // Table: basic packet, truncated packet, stray byte, zero payload,
      // back-to-back headers; both consumers always ready.
      for (int i = 0; i < 23; i++) begin
         send(vecs[i].ctl, vecs[i].data);
         check($sformatf("vec%0d", i),
               64'({pl_valid, pl_data, pl_last, desc_valid, desc_cmd, desc_src,
                    desc_len, desc_err, drop_cnt}),
               64'({vecs[i].plv, vecs[i].pld, vecs[i].pll, vecs[i].dv, vecs[i].cmd,
                    vecs[i].src, vecs[i].len, vecs[i].err, vecs[i].drop}));
      end

      // Over-long packet: only 63 bytes kept, err LONG.
      mon_en = 1'b1;
      for (int i = 0; i < 63; i++) pl_q.push_back({(i == 62), 8'(i + 1)});
      desc_q.push_back({8'h05, 8'h42, 6'd63, 2'd2});
      send(1'b1, 8'h05);
      send(1'b0, 8'h42);
      for (int i = 0; i < 70; i++) send(1'b0, 8'(i + 1));
      send(1'b1, 8'h00);
      wait_drain("long_drain", 200);

      // Payload overflow with consumer stalled: 17 kept, 3 dropped, err OVF,
      // final byte held in staging until space appears.
      do_reset();
      pl_ready = 1'b0;
      for (int i = 0; i < 17; i++) pl_q.push_back({(i == 16), 8'(8'h80 + i)});
      desc_q.push_back({8'h07, 8'h41, 6'd17, 2'd3});
      send(1'b1, 8'h07);
      send(1'b0, 8'h41);
      for (int i = 0; i < 20; i++) send(1'b0, 8'(8'h80 + i));
      send(1'b1, 8'h00);
      check("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
      check("ovf_head", 64'({pl_valid, pl_last, pl_data}), 64'({1'b1, 1'b0, 8'h80}));
      tick(); tick(); tick();
      check("ovf_head_stable", 64'({pl_valid, pl_last, pl_data}), 64'({1'b1, 1'b0, 8'h80}));
      pl_ready = 1'b1;
      wait_drain("ovf_drain", 100);

      // Descriptor FIFO full: fifth header is dropped along with its bytes.
      do_reset();
      desc_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         desc_q.push_back({8'(8'h60 + k), 8'(8'h40 + k), 6'd0, 2'd0});
         send(1'b1, 8'(8'h60 + k));
         send(1'b0, 8'(8'h40 + k));
         send(1'b1, 8'h00);
      end
      send(1'b1, 8'h70);
      send(1'b0, 8'h40);
      send(1'b0, 8'h99);
      send(1'b1, 8'h00);
      check("descfull_drop_cnt", 64'(drop_cnt), 64'd1);
      check("descfull_no_payload", 64'(pl_valid), 64'd0);
      desc_ready = 1'b1;
      wait_drain("descfull_drain", 50);
      tick(); tick();
      check("descfull_no_fifth", 64'(desc_valid), 64'd0);
      mon_en = 1'b0;

      // Reset in the middle of a packet discards it.
      do_reset();
      pl_ready   = 1'b0;
      desc_ready = 1'b0;
      send(1'b1, 8'h02);
      send(1'b0, 8'h43);
      send(1'b0, 8'hEE);
      send(1'b0, 8'hEF);
      check("midpkt_pl_valid", 64'({pl_valid, pl_data}), 64'({1'b1, 8'hEE}));
      do_reset();
      check("midpkt_reset_outputs",
            64'({pl_valid, pl_data, pl_last, desc_valid, desc_cmd, desc_src,
                 desc_len, desc_err, drop_cnt}), 64'd0);
      send(1'b0, 8'h77);
      check("midpkt_stray_drop", 64'(drop_cnt), 64'd1);
      send(1'b1, 8'h00);
      check("midpkt_no_desc", 64'({desc_valid, pl_valid}), 64'd0);

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) send(1'b0, 8'h5A);
      check("drop_saturate", 64'(drop_cnt), 64'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
